// File: rtl/tp_montre_cpu_oci_pkg.sv
// Shared constants and state encoding for the trace-code frame sequencer.
package tp_montre_cpu_oci_pkg;

  localparam int CODE_W  = 2;
  localparam int DEPTH   = 15;
  localparam int FRAME_W = 30;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    ENDED = 2'd3
  } state_t;

endpackage

// File: rtl/tp_montre_cpu_oci_frame_slot.sv
// One-deep valid/ready output register holding a completed frame.
module tp_montre_cpu_oci_frame_slot
  import tp_montre_cpu_oci_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic [CNT_W-1:0]   load_count,
  input  logic               ready,
  output logic               valid,
  output logic [FRAME_W-1:0] data,
  output logic [CNT_W-1:0]   count
);

  // Load takes priority so an accept and a new load in one cycle are back-to-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      count <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      count <= load_count;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tp_montre_cpu_oci_dct_seq.sv
// Collects trace codes into 15-code frames and hands them to a valid/ready
// consumer; supports explicit flush and an end-of-test drain sequence.
module tp_montre_cpu_oci_dct_seq
  import tp_montre_cpu_oci_pkg::*;
#(
  parameter int CODE_W = tp_montre_cpu_oci_pkg::CODE_W,
  parameter int DEPTH  = tp_montre_cpu_oci_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trace_valid,
  input  logic [CODE_W-1:0]  trace_code,
  input  logic               trace_flush,
  input  logic               test_ending,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame_data,
  output logic [CNT_W-1:0]   frame_count,
  output logic [FRAME_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               overflow,
  output logic               test_has_ended
);

  state_t             state, state_nxt;
  logic               flush_pend, flush_pend_nxt;
  logic               offer, slot_free, full, flush_req;
  logic               accept, handoff, drop;
  logic [FRAME_W-1:0] post_buf, next_buf;
  logic [CNT_W-1:0]   post_cnt, next_cnt;

  // Accept/handoff decision. A full buffer (only possible while the slot is
  // busy) is handed off as-is once the slot frees; a code offered in that
  // same cycle starts the fresh buffer instead of being dropped.
  always_comb begin
    offer     = (state == RUN) && !test_ending && trace_valid;
    slot_free = !frame_valid || frame_ready;
    full      = (dct_count == CNT_W'(DEPTH));
    flush_req = trace_flush || flush_pend;
    accept    = 1'b0;
    handoff   = 1'b0;
    drop      = 1'b0;
    post_buf  = dct_buffer;
    post_cnt  = dct_count;
    next_buf  = dct_buffer;
    next_cnt  = dct_count;
    if (full) begin
      handoff = slot_free;
      accept  = offer && slot_free;
      drop    = offer && !slot_free;
      if (handoff) begin
        next_buf = accept ? FRAME_W'(trace_code) : '0;
        next_cnt = accept ? CNT_W'(1) : '0;
      end
    end else begin
      accept = offer;
      if (accept) begin
        post_buf = {dct_buffer[FRAME_W-CODE_W-1:0], trace_code};
        post_cnt = dct_count + CNT_W'(1);
      end
      handoff = slot_free &&
                ((post_cnt == CNT_W'(DEPTH)) ||
                 (flush_req && (post_cnt != '0)) ||
                 ((state == FLUSH) && (dct_count != '0)));
      next_buf = handoff ? '0 : post_buf;
      next_cnt = handoff ? '0 : post_cnt;
    end
    flush_pend_nxt = flush_pend;
    if (handoff)
      flush_pend_nxt = 1'b0;
    else if (trace_flush && (post_cnt != '0))
      flush_pend_nxt = 1'b1;
  end

  // End-of-test sequencing: stop intake, flush the partial frame, wait for
  // the consumer to take the last frame, then park in ENDED.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (test_ending) state_nxt = FLUSH;
      FLUSH:   if (handoff || (dct_count == '0)) state_nxt = DRAIN;
      DRAIN:   if (!frame_valid || frame_ready) state_nxt = ENDED;
      ENDED:   state_nxt = ENDED;
      default: state_nxt = RUN;
    endcase
  end

  // Collection buffer, flush request memory, sticky overflow and state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      dct_buffer     <= '0;
      dct_count      <= '0;
      flush_pend     <= 1'b0;
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_nxt;
      dct_buffer     <= next_buf;
      dct_count      <= next_cnt;
      flush_pend     <= flush_pend_nxt;
      test_has_ended <= (state_nxt == ENDED);
      if (drop) overflow <= 1'b1;
    end
  end

  tp_montre_cpu_oci_frame_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (handoff),
    .load_data  (full ? dct_buffer : post_buf),
    .load_count (post_cnt),
    .ready      (frame_ready),
    .valid      (frame_valid),
    .data       (frame_data),
    .count      (frame_count)
  );

endmodule

// File: tb/tb_tp_montre_cpu_oci_dct_seq.sv
module tb_tp_montre_cpu_oci_dct_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_valid, trace_flush, test_ending, frame_ready;
  logic [1:0]  trace_code;
  logic        frame_valid, overflow, test_has_ended;
  logic [29:0] frame_data, dct_buffer;
  logic [3:0]  frame_count, dct_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          n;
    logic [29:0] codes;     // code i at bits [2i+1:2i]
    logic [3:0]  exp_cnt;   // 0 means no frame expected
    logic [29:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  tp_montre_cpu_oci_dct_seq dut (
    .clk(clk), .reset(reset), .trace_valid(trace_valid), .trace_code(trace_code),
    .trace_flush(trace_flush), .test_ending(test_ending), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .frame_count(frame_count),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
    .test_has_ended(test_has_ended)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    trace_valid = 1'b1;
    trace_code  = c;
    step();
    trace_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  initial begin
    logic [29:0] first, mb, f0, f1;
    logic        stable;
    int          hs;

    reset = 1'b1; trace_valid = 0; trace_code = 0; trace_flush = 0;
    test_ending = 0; frame_ready = 0;
    vecs[0] = '{3,  30'h0000001B, 4'd3,  30'h00000039};
    vecs[1] = '{1,  30'h00000002, 4'd1,  30'h00000002};
    vecs[2] = '{4,  30'h000000C5, 4'd4,  30'h00000053};
    vecs[3] = '{2,  30'h0000000C, 4'd2,  30'h00000003};
    vecs[4] = '{15, 30'h24E4E4E4, 4'd15, 30'h06C6C6C6};
    vecs[5] = '{0,  30'h00000000, 4'd0,  30'h00000000};
    step();

    // reset state
    chk("rst_frame_valid", 32'(frame_valid), 0);
    chk("rst_dct_count", 32'(dct_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_ended", 32'(test_has_ended), 0);
    reset = 1'b0;
    step();

    // table: n codes, then one flush cycle; consumer stalled
    for (int v = 0; v < 6; v++) begin
      do_reset();
      frame_ready = 1'b0;
      for (int i = 0; i < vecs[v].n; i++) send(vecs[v].codes[2*i +: 2]);
      trace_flush = 1'b1;
      step();
      trace_flush = 1'b0;
      chk($sformatf("v%0d_valid", v), 32'(frame_valid), 32'(vecs[v].exp_cnt != 0));
      chk($sformatf("v%0d_count", v), 32'(frame_count), 32'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_data", v), 32'(frame_data), 32'(vecs[v].exp_data));
      chk($sformatf("v%0d_dct_count", v), 32'(dct_count), 0);
      chk($sformatf("v%0d_overflow", v), 32'(overflow), 0);
    end

    // 15 codes with consumer ready: frame on 15th edge, taken on the next
    do_reset();
    frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(2'(i % 4));
    chk("rdy15_valid", 32'(frame_valid), 1);
    chk("rdy15_count", 32'(frame_count), 15);
    chk("rdy15_data", 32'(frame_data), 32'h1B1B1B1B >> 2);
    chk("rdy15_dct_count", 32'(dct_count), 0);
    step();
    chk("rdy15_taken", 32'(frame_valid), 0);

    // stalled consumer, 31 codes: first frame held, buffer fills, overflow
    do_reset();
    frame_ready = 1'b0;
    first = '0;
    mb = '0;
    stable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      first = {first[27:0], 2'(i % 4)};
      send(2'(i % 4));
    end
    for (int i = 15; i < 30; i++) begin
      mb = {mb[27:0], 2'(i % 4)};
      send(2'(i % 4));
      if (frame_data !== first || frame_count !== 4'd15 || !frame_valid) stable = 1'b0;
    end
    chk("stall_held_stable", 32'(stable), 1);
    chk("stall_full_count", 32'(dct_count), 15);
    chk("stall_no_ovf_yet", 32'(overflow), 0);
    send(2'(30 % 4));
    chk("stall_ovf", 32'(overflow), 1);
    chk("stall_buf_unchanged", 32'(dct_buffer), 32'(mb));
    chk("stall_cnt_unchanged", 32'(dct_count), 15);
    chk("stall_first_frame", 32'(frame_data), 32'(first));
    frame_ready = 1'b1;
    step();
    chk("b2b_valid_stays", 32'(frame_valid), 1);
    chk("b2b_second_frame", 32'(frame_data), 32'(mb));
    chk("b2b_second_count", 32'(frame_count), 15);
    chk("b2b_dct_cleared", 32'(dct_count), 0);
    step();
    chk("b2b_drained", 32'(frame_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // 30 consecutive codes with consumer always ready: two whole frames
    do_reset();
    frame_ready = 1'b1;
    hs = 0; f0 = '0; f1 = '0; first = '0; mb = '0;
    for (int i = 0; i < 34; i++) begin
      if (frame_valid && frame_ready) begin
        if (hs == 0) f0 = frame_data; else f1 = frame_data;
        hs++;
      end
      if (i < 15) first = {first[27:0], 2'(i % 4)};
      else if (i < 30) mb = {mb[27:0], 2'(i % 4)};
      if (i < 30) send(2'(i % 4)); else step();
    end
    chk("run30_handshakes", 32'(hs), 2);
    chk("run30_frame0", 32'(f0), 32'(first));
    chk("run30_frame1", 32'(f1), 32'(mb));
    chk("run30_no_ovf", 32'(overflow), 0);

    // flush requested while slot busy is remembered until the slot frees
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'(i % 4));
    send(2'd3);
    send(2'd1);
    trace_flush = 1'b1;
    step();
    trace_flush = 1'b0;
    step();
    chk("pend_still_held", 32'(frame_count), 15);
    chk("pend_dct_count", 32'(dct_count), 2);
    frame_ready = 1'b1;
    step();
    chk("pend_frame_count", 32'(frame_count), 2);
    chk("pend_frame_data", 32'(frame_data), 32'hD);
    chk("pend_dct_cleared", 32'(dct_count), 0);
    frame_ready = 1'b0;

    // end-of-test drain with a stalled consumer
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'(i % 4));
    chk("end_pre_count", 32'(dct_count), 5);
    test_ending = 1'b1;
    trace_valid = 1'b1;
    trace_code  = 2'd3;
    step();
    chk("end_no_accept", 32'(dct_count), 5);
    step();
    chk("end_handoff_valid", 32'(frame_valid), 1);
    chk("end_handoff_count", 32'(frame_count), 5);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("end_wait%0d_ended", i), 32'(test_has_ended), 0);
    end
    chk("end_ignored_codes", 32'(dct_count), 0);
    frame_ready = 1'b1;
    step();
    chk("end_accepted", 32'(frame_valid), 0);
    chk("end_ended", 32'(test_has_ended), 1);
    frame_ready = 1'b0;
    test_ending = 1'b0;
    step();
    step();
    chk("end_hold", 32'(test_has_ended), 1);
    chk("end_ignored_after", 32'(dct_count), 0);
    chk("end_no_frame", 32'(frame_valid), 0);
    trace_valid = 1'b0;

    // asynchronous reset mid-frame
    do_reset();
    frame_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(2'(i % 4));
    chk("ar_pre_valid", 32'(frame_valid), 1);
    chk("ar_pre_count", 32'(dct_count), 9);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_dct_buffer", 32'(dct_buffer), 0);
    chk("ar_dct_count", 32'(dct_count), 0);
    chk("ar_frame_data", 32'(frame_data), 0);
    chk("ar_frame_count", 32'(frame_count), 0);
    chk("ar_frame_valid", 32'(frame_valid), 0);
    chk("ar_overflow", 32'(overflow), 0);
    chk("ar_ended", 32'(test_has_ended), 0);
    reset = 1'b0;
    step();
    chk("ar_after_valid", 32'(frame_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
